// File: rtl/ram_fill_writer_if.sv
// Write-stream handshake bundle for ram_fill_writer.
// The master drives words. The slave (the RAM) drives ready.
interface ram_fill_writer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/ram_fill_writer.sv
// 8x4 synchronous RAM with a fill sequencer. A pass writes every location once,
// starting at start_addr and wrapping. The read port is independent and registered.
module ram_fill_writer #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    ram_fill_writer_if.slave      wr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  handshake;

    // wr_ready comes from the state register only, so wr_valid has no combinational path to it.
    assign handshake     = wr.wr_valid & wr.wr_ready;
    assign words_written = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = FILL;
                    ptr_next   = start_addr;
                    count_next = '0;
                end
            end
            FILL: begin
                if (handshake) begin
                    ptr_next   = ptr_reg + ADDR_WIDTH'(1);
                    count_next = count_reg + (ADDR_WIDTH+1)'(1);
                    if (count_reg == LAST_COUNT) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr.wr_ready = (state_reg == FILL);
        busy        = (state_reg == FILL);
        done        = (state_reg == DONE);
    end

    // A read and a write to the same address in one cycle return the old word.
    // The array is never cleared by reset. Only the output register is.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            if (handshake) begin
                mem[ptr_reg] <= wr.wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_ram_fill_writer.sv
// Scoreboarded random test of ram_fill_writer against a pass-level reference model.
// The driver pushes the expected post-edge outputs. The monitor pops and compares them.
module tb_ram_fill_writer;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [2:0] start_addr, rd_addr;
    logic [3:0] rd_data;
    logic       busy, done;
    logic [3:0] words_written;

    ram_fill_writer_if #(.DATA_WIDTH(4)) wif ();

    ram_fill_writer #(.ADDR_WIDTH(3), .DATA_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .wr(wif.slave), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       chk_data;
        bit [3:0] rd_data;
        bit       ready;
        bit       done;
        bit [3:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a pass covers DEPTH consecutive addresses from base, modulo 8.
    bit       in_pass = 0;
    bit       finished = 0;
    int       base = 0;
    int       accepted = 0;
    bit [3:0] model_mem [8];
    bit       known [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_ready", {7'd0, wif.wr_ready}, {7'd0, e.ready});
            check("busy", {7'd0, busy}, {7'd0, e.ready});
            check("done", {7'd0, done}, {7'd0, e.done});
            check("words_written", {4'd0, words_written}, {4'd0, e.count});
            if (e.chk_data) check("rd_data", {4'd0, rd_data}, {4'd0, e.rd_data});
        end
    end

    function automatic int wr_addr();
        return (base + accepted) % 8;
    endfunction

    // One clock cycle: drive the inputs, advance the model, push the expectation, take the edge.
    task automatic step(input bit rst, input bit st, input int sa, input bit v,
                        input int d, input int ra);
        exp_t e;
        bit   ready;
        reset = rst; start = st; start_addr = 3'(sa);
        wif.wr_valid = v; wif.wr_data = 4'(d); rd_addr = 3'(ra);
        ready = in_pass && !finished;
        if (rst) begin
            in_pass = 0; finished = 0; accepted = 0;
            e.chk_data = 1; e.rd_data = 0;
        end else begin
            e.chk_data = known[ra]; e.rd_data = model_mem[ra];
            if (ready && v) begin
                $display("write addr=%0d data=%0h word=%0d", wr_addr(), d & 15, accepted + 1);
                model_mem[wr_addr()] = 4'(d);
                known[wr_addr()] = 1;
                accepted++;
                if (accepted == 8) finished = 1;
            end else if (!ready && st) begin
                in_pass = 1; finished = 0; base = sa; accepted = 0;
            end
        end
        e.ready = in_pass && !finished;
        e.done  = finished;
        e.count = 4'(accepted);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sweep();
        for (int a = 0; a < 9; a++) step(0, 0, 0, 0, 0, a % 8);
    endtask

    int words_a [8] = '{10, 11, 12, 13, 14, 15, 0, 1};

    initial begin
        for (int i = 0; i < 8; i++) known[i] = 0;
        #1;
        // Reset with random inputs.
        for (int i = 0; i < 2; i++)
            step(1, 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
        step(0, 0, 0, 0, 0, 0);

        // Linear fill from 0 with words 1..8, then sweep the read port.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i + 1, $urandom);
        step(0, 0, 0, 1, 5, 0);
        idle_sweep();

        // Wrap fill from 5, with start pulses mid-pass that must be ignored.
        step(0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, i % 3 == 1, 2, 1, words_a[i], $urandom);
        idle_sweep();

        // Gapped stream with valid = 1,0,0 repeating, bounded by a cycle budget.
        step(0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 40 && !finished; i++) step(0, 0, 0, i % 3 == 0, $urandom, $urandom);
        step(0, 0, 0, 0, 0, 0);
        idle_sweep();

        // Reset mid-fill after three writes of 9, then refill over them.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 9, 7);
        step(1, 1, 4, 1, 3, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 0, a);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 2 + i, 0);
        idle_sweep();

        // Collision: fill with 4s, then fill with 7s while reading the write address.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 4, 0);
        step(0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            int a;
            a = wr_addr();
            step(0, 0, 0, 1, 7, a);
            step(0, 0, 0, 0, 0, a);
        end
        idle_sweep();

        // Random passes with random valid, start and read traffic.
        for (int p = 0; p < 6; p++) begin
            step(0, 1, $urandom, 1'($urandom), $urandom, $urandom);
            for (int i = 0; i < 60 && !finished; i++)
                step(0, 1'($urandom_range(0, 3) == 0), $urandom,
                     1'($urandom), $urandom, $urandom);
            if (p == 3) step(1, 0, 0, 0, 0, 0);
            idle_sweep();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_fill_writer.md
# ram_fill_writer

Sequential write-side companion to the 8x4 ROM lookup: an 8-word x 4-bit synchronous RAM with a built-in fill sequencer. On a start pulse it accepts words over a valid/ready stream and writes them to auto-incrementing addresses from a programmable start address, wrapping modulo depth, until every location has been written once. An independent registered read port exposes the contents to downstream consumers the same way the ROM does: address in, data out.

## Interface
Parameters:
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH (8)
- DATA_WIDTH, 4, word width

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a fill pass (sampled in IDLE and DONE only)
- start_addr  input  ADDR_WIDTH  first address of the pass, sampled with start
- wr_valid  input  1  wr_data holds a valid word
- wr_ready  output  1  block accepts a word this cycle
- wr_data  input  DATA_WIDTH  word to store
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_WIDTH  registered read data
- busy  output  1  high in FILL
- done  output  1  high in DONE (pass complete)
- words_written  output  ADDR_WIDTH+1  handshakes accepted in current pass, 0..DEPTH

## Operation
- States: IDLE, FILL, DONE. Outputs wr_ready, busy and done decode directly from the state register (Moore): wr_ready = busy = (state==FILL); done = (state==DONE).
- IDLE: start=1 -> FILL; ptr <= start_addr; words_written <= 0.
- FILL: a handshake (wr_valid & wr_ready) writes mem[ptr] <= wr_data, increments ptr modulo DEPTH (7 -> 0), and increments words_written. No handshake means no write; ptr and count hold. start is ignored.
- FILL -> DONE on the handshake that brings words_written to DEPTH, which is the 8th write. No further writes are accepted.
- DONE: holds. words_written stays at DEPTH. start=1 -> FILL with a new start_addr and count 0; done drops the next cycle.
- Read port: rd_data <= mem[rd_addr] every cycle, in all states.
- Read-before-write: if rd_addr equals the write address in a handshake cycle, rd_data returns the old contents. New data is visible one cycle later.
- Reset: state <= IDLE, ptr <= 0, words_written <= 0, rd_data <= 0. As a result wr_ready, busy and done are all 0. Memory array contents are not cleared.
- Reset during FILL aborts the pass. Words already written stay in memory. Reset has priority over start and over a coincident handshake, so no write occurs in the reset cycle.

## Timing
- start is sampled on edge N; busy and wr_ready are high from cycle N+1.
- The first handshake is possible in cycle N+1. Maximum throughput is one word per cycle.
- After the 8th handshake on edge M, done is high and wr_ready is low from cycle M+1.
- A back-to-back fill from a start in IDLE to done takes 1 + 8 = 9 edges.
- Read latency is 1 cycle: rd_addr sampled on edge K appears on rd_data after edge K.
- wr_ready does not depend combinationally on wr_valid, so there is no combinational path from wr_valid to wr_ready.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> rd_data=0, wr_ready=0, busy=0, done=0, words_written=0.
- Linear fill: start with start_addr=0, then 8 consecutive valid words 1..8 -> done rises 1 cycle after the 8th handshake and words_written=8. Sweeping rd_addr 0..7 then returns 1..8, each one cycle late.
- Wrap fill: start_addr=5, words A,B,C,D,E,F,0,1 -> mem[5..7]=A,B,C and mem[0..4]=D,E,F,0,1. Also check that start is ignored mid-pass (ptr unchanged).
- Gapped stream: toggle wr_valid 1,0,0,1,... -> writes occur only on handshake cycles, words_written steps only then, and done arrives after exactly 8 handshakes.
- Reset mid-fill: reset after 3 writes of 9,9,9 from addr 0 -> IDLE with count 0, and mem[0..2] still read 9. A new start with start_addr=0 overwrites them.
- Read/write collision: during FILL, set rd_addr equal to ptr with old value 4 and new value 7 -> rd_data=4 on the next cycle and 7 on the cycle after.
